dm_display_scanner: RTL and testbench

DM_DISPLAY_SCANNER -- requirements
Module: dm_display_scanner

---
 rtl/dm_display_pkg.sv | 22 ++
 rtl/hex_to_7seg.sv | 11 +
 rtl/dm_display_scanner.sv | 141 ++++++++++++++
 tb/tb_dm_display_scanner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_display_pkg.sv
// Shared types and constants for the data-memory display scanner.
// Holds the digit-slot enum and the active-low hex segment table.
package dm_display_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_sel_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Segment order gfedcba, active-low.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment encoder.
module hex_to_7seg
  import dm_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/dm_display_scanner.sv
// Steps a data-memory debug pointer (auto dwell or manual pulses) and multiplexes
// either the pointed byte or the current instruction onto a 4-digit display.
module dm_display_scanner
  import dm_display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES   = 50_000_000,
  parameter int unsigned REFRESH_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode,
  input  logic        auto_en,
  input  logic        step_up,
  input  logic        step_down,
  input  logic [7:0]  data_on_dm,
  input  logic [15:0] curr_inst,
  output logic [3:0]  addr_on_dm,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int unsigned DwellW   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned RefreshW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [DwellW-1:0]   DwellLast   = DwellW'(DWELL_CYCLES - 1);
  localparam logic [RefreshW-1:0] RefreshLast = RefreshW'(REFRESH_CYCLES - 1);

  logic [3:0]          ptr_q, ptr_d;
  logic [DwellW-1:0]   dwell_q, dwell_d;
  logic [RefreshW-1:0] refresh_q, refresh_d;
  digit_sel_e          slot_q, slot_d;
  logic [7:0]          capture_q;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          an_q, an_d;
  logic                dp_q, dp_d;
  logic [3:0]          hex_nib;
  logic [6:0]          hex_seg;
  logic                blank;

  // Pointer and dwell; manual pulses take priority over the auto step.
  always_comb begin
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    if (step_up || step_down) begin
      dwell_d = '0;
      if (step_up && !step_down) begin
        ptr_d = ptr_q + 4'd1;
      end else if (step_down && !step_up) begin
        ptr_d = ptr_q - 4'd1;
      end
    end else if (auto_en) begin
      if (dwell_q == DwellLast) begin
        dwell_d = '0;
        ptr_d   = ptr_q + 4'd1;
      end else begin
        dwell_d = dwell_q + DwellW'(1);
      end
    end else begin
      dwell_d = '0;
    end
  end

  // Digit-slot state machine, advanced by the refresh counter.
  always_comb begin
    refresh_d = refresh_q + RefreshW'(1);
    slot_d    = slot_q;
    if (refresh_q == RefreshLast) begin
      refresh_d = '0;
      unique case (slot_q)
        DIG0:    slot_d = DIG1;
        DIG1:    slot_d = DIG2;
        DIG2:    slot_d = DIG3;
        DIG3:    slot_d = DIG0;
        default: slot_d = DIG0;
      endcase
    end
  end

  // Content and anode decode for the current slot.
  always_comb begin
    hex_nib = 4'h0;
    blank   = 1'b0;
    an_d    = 4'b1111;
    dp_d    = 1'b1;
    unique case (slot_q)
      DIG0: begin
        hex_nib = mode ? curr_inst[3:0] : capture_q[3:0];
        an_d    = 4'b1110;
        dp_d    = ~mode;
      end
      DIG1: begin
        hex_nib = mode ? curr_inst[7:4] : capture_q[7:4];
        an_d    = 4'b1101;
      end
      DIG2: begin
        hex_nib = curr_inst[11:8];
        blank   = ~mode;
        an_d    = mode ? 4'b1011 : 4'b1111;
      end
      DIG3: begin
        hex_nib = mode ? curr_inst[15:12] : ptr_q;
        an_d    = 4'b0111;
      end
      default: ;
    endcase
    seg_d = blank ? SEG_BLANK : hex_seg;
  end

  hex_to_7seg u_hex_to_7seg (
    .hex (hex_nib),
    .seg (hex_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      dwell_q   <= '0;
      refresh_q <= '0;
      slot_q    <= DIG0;
      capture_q <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= 4'b1111;
      dp_q      <= 1'b1;
    end else begin
      ptr_q     <= ptr_d;
      dwell_q   <= dwell_d;
      refresh_q <= refresh_d;
      slot_q    <= slot_d;
      capture_q <= data_on_dm;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
    end
  end

  assign addr_on_dm = ptr_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_dm_display_scanner.sv
// Scoreboard bench for dm_display_scanner: a per-cycle reference model pushes expected
// outputs into a queue and a negedge monitor pops and compares them against the DUT.
module tb_dm_display_scanner;

  localparam int unsigned Dwell   = 3;
  localparam int unsigned Refresh = 4;

  typedef struct {
    logic [3:0] addr;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, mode, auto_en, step_up, step_down;
  logic [7:0]  data_on_dm;
  logic [15:0] curr_inst;
  logic [3:0]  addr_on_dm;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  logic [7:0] mem [16];
  logic [6:0] seg_ref [16];
  exp_t       exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  bit stim_done = 1'b0;

  // Reference model state
  int         m_ptr, m_dwell, m_ref, m_slot;
  logic [7:0] m_cap;

  dm_display_scanner #(
    .DWELL_CYCLES   (Dwell),
    .REFRESH_CYCLES (Refresh)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .auto_en    (auto_en),
    .step_up    (step_up),
    .step_down  (step_down),
    .data_on_dm (data_on_dm),
    .curr_inst  (curr_inst),
    .addr_on_dm (addr_on_dm),
    .seg        (seg),
    .an         (an),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  assign data_on_dm = mem[addr_on_dm];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: model evaluates with the inputs present at the edge, then pulses drop.
  task automatic cycle();
    exp_t       e;
    logic [3:0] nib;
    bit         blank;
    @(posedge clk);
    if (reset) begin
      e.seg = 7'h7F; e.an = 4'hF; e.dp = 1'b1;
      m_ptr = 0; m_dwell = 0; m_ref = 0; m_slot = 0; m_cap = 8'h00;
    end else begin
      blank = 1'b0;
      if (mode) begin
        nib = 4'((curr_inst >> (4 * m_slot)) & 16'hF);
      end else if (m_slot == 3) begin
        nib = 4'(m_ptr);
      end else if (m_slot == 2) begin
        nib = 4'h0; blank = 1'b1;
      end else if (m_slot == 1) begin
        nib = m_cap[7:4];
      end else begin
        nib = m_cap[3:0];
      end
      e.an = 4'hF;
      if (!blank) e.an[m_slot] = 1'b0;
      e.seg = blank ? 7'h7F : seg_ref[nib];
      e.dp  = !(mode && m_slot == 0);
      m_cap = mem[m_ptr];
      if (step_up || step_down) begin
        m_dwell = 0;
        if (step_up && !step_down) m_ptr = (m_ptr + 1) % 16;
        else if (step_down && !step_up) m_ptr = (m_ptr + 15) % 16;
      end else if (auto_en) begin
        if (m_dwell == Dwell - 1) begin
          m_dwell = 0; m_ptr = (m_ptr + 1) % 16;
        end else begin
          m_dwell++;
        end
      end else begin
        m_dwell = 0;
      end
      if (m_ref == Refresh - 1) begin
        m_ref = 0; m_slot = (m_slot + 1) % 4;
      end else begin
        m_ref++;
      end
    end
    e.addr = 4'(m_ptr);
    exp_q.push_back(e);
    #1;
    step_up   = 1'b0;
    step_down = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("addr_on_dm", 16'(addr_on_dm), 16'(e.addr));
        chk("seg", 16'(seg), 16'(e.seg));
        chk("an", 16'(an), 16'(e.an));
        chk("dp", 16'(dp), 16'(e.dp));
      end else if (stim_done) begin
        break;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'hA5;
    reset = 1'b1; mode = 1'b0; auto_en = 1'b0; step_up = 1'b0; step_down = 1'b0;
    curr_inst = 16'h0000;
    m_ptr = 0; m_dwell = 0; m_ref = 0; m_slot = 0; m_cap = 8'h00;

    // Reset, then mode-0 display of byte A5 at pointer 0
    run(3);
    reset = 1'b0;
    run(20);

    // Walk to 15, wrap up to 0, wrap down to 15
    for (int i = 0; i < 15; i++) begin
      step_up = 1'b1; cycle();
    end
    run(2);
    step_up = 1'b1; cycle();
    run(2);
    step_down = 1'b1; cycle();
    run(2);

    // Auto-scan, then a manual step mid-dwell
    auto_en = 1'b1;
    run(10);
    for (int i = 0; i < 8 && m_dwell != 2; i++) cycle();
    step_up = 1'b1; cycle();
    run(7);

    // Simultaneous pulses
    step_up = 1'b1; step_down = 1'b1; cycle();
    run(2);
    auto_en = 1'b0;

    // Instruction view
    mode = 1'b1; curr_inst = 16'h1F08;
    run(20);

    // Reset during DIG2 with pointer 7
    mode = 1'b0;
    for (int i = 0; i < 16 && m_ptr != 7; i++) begin
      step_up = 1'b1; cycle();
    end
    for (int i = 0; i < 16 && m_slot != 2; i++) cycle();
    cycle();
    reset = 1'b1; cycle();
    reset = 1'b0;
    run(6);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      mode      = 1'($urandom_range(0, 1));
      auto_en   = ($urandom_range(0, 3) != 0);
      step_up   = ($urandom_range(0, 9) == 0);
      step_down = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) curr_inst = 16'($urandom_range(0, 65535));
      cycle();
    end
    reset = 1'b0;
    run(2);
    stim_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
